// File: rtl/recip_div_ctrl_pkg.sv
// Shared widths, FSM states and constants for the reciprocal-multiply divider controller.
package recip_div_pkg;

   localparam int DIVIDEND_WIDTH = 8;
   localparam int DIVISOR_WIDTH  = 5;
   localparam int WIDTH_INVERSE  = 17;
   localparam int WIDTH_SHIFT    = 5;
   localparam int PRODUCT_WIDTH  = DIVIDEND_WIDTH + WIDTH_INVERSE;
   localparam int COUNT_WIDTH    = $clog2(DIVIDEND_WIDTH);

   localparam logic [DIVIDEND_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MUL,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/recip_div_ctrl_if.sv
// Request and result handshake bundle between the two front-ends, the consumer and the divider controller.
interface recip_div_ctrl_if;
   import recip_div_pkg::*;

   logic                      req0_valid;
   logic                      req0_ready;
   logic [DIVIDEND_WIDTH-1:0] req0_dividend;
   logic [DIVISOR_WIDTH-1:0]  req0_divisor;

   logic                      req1_valid;
   logic                      req1_ready;
   logic [DIVIDEND_WIDTH-1:0] req1_dividend;
   logic [DIVISOR_WIDTH-1:0]  req1_divisor;

   logic                      out_valid;
   logic                      out_ready;
   logic [DIVIDEND_WIDTH-1:0] out_quotient;
   logic [DIVISOR_WIDTH-1:0]  out_remainder;
   logic                      out_id;
   logic                      out_div_zero;

   modport master (
      output req0_valid, req0_dividend, req0_divisor,
      output req1_valid, req1_dividend, req1_divisor,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_quotient, out_remainder, out_id, out_div_zero
   );

   modport slave (
      input  req0_valid, req0_dividend, req0_divisor,
      input  req1_valid, req1_dividend, req1_divisor,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_quotient, out_remainder, out_id, out_div_zero
   );

endinterface

// File: rtl/recip_div_ctrl_inverse_table.sv
// Reciprocal lookup: inverse = ceil(2^shift / divisor) normalised so bit 16 is always set.
module inverse_table
   import recip_div_pkg::*;
#(
   parameter int WIDTH_SHIFT = 5
) (
   input  logic [DIVISOR_WIDTH-1:0] divisor,
   output logic [WIDTH_INVERSE-1:0] inverse,
   output logic [WIDTH_SHIFT-1:0]   shift
);

   logic [4:0] shift_raw;

   // Powers of two use an exact 2^16 inverse; other divisors get one extra shift bit of precision.
   always_comb begin
      shift_raw = 5'd16;
      inverse   = 17'd65536;
      case (divisor)
         5'd1:  begin shift_raw = 5'd16; inverse = 17'd65536;  end
         5'd2:  begin shift_raw = 5'd17; inverse = 17'd65536;  end
         5'd3:  begin shift_raw = 5'd18; inverse = 17'd87382;  end
         5'd4:  begin shift_raw = 5'd18; inverse = 17'd65536;  end
         5'd5:  begin shift_raw = 5'd19; inverse = 17'd104858; end
         5'd6:  begin shift_raw = 5'd19; inverse = 17'd87382;  end
         5'd7:  begin shift_raw = 5'd19; inverse = 17'd74899;  end
         5'd8:  begin shift_raw = 5'd19; inverse = 17'd65536;  end
         5'd9:  begin shift_raw = 5'd20; inverse = 17'd116509; end
         5'd10: begin shift_raw = 5'd20; inverse = 17'd104858; end
         5'd11: begin shift_raw = 5'd20; inverse = 17'd95326;  end
         5'd12: begin shift_raw = 5'd20; inverse = 17'd87382;  end
         5'd13: begin shift_raw = 5'd20; inverse = 17'd80660;  end
         5'd14: begin shift_raw = 5'd20; inverse = 17'd74899;  end
         5'd15: begin shift_raw = 5'd20; inverse = 17'd69906;  end
         5'd16: begin shift_raw = 5'd20; inverse = 17'd65536;  end
         5'd17: begin shift_raw = 5'd21; inverse = 17'd123362; end
         5'd18: begin shift_raw = 5'd21; inverse = 17'd116509; end
         5'd19: begin shift_raw = 5'd21; inverse = 17'd110377; end
         5'd20: begin shift_raw = 5'd21; inverse = 17'd104858; end
         5'd21: begin shift_raw = 5'd21; inverse = 17'd99865;  end
         5'd22: begin shift_raw = 5'd21; inverse = 17'd95326;  end
         5'd23: begin shift_raw = 5'd21; inverse = 17'd91181;  end
         5'd24: begin shift_raw = 5'd21; inverse = 17'd87382;  end
         5'd25: begin shift_raw = 5'd21; inverse = 17'd83887;  end
         5'd26: begin shift_raw = 5'd21; inverse = 17'd80660;  end
         5'd27: begin shift_raw = 5'd21; inverse = 17'd77673;  end
         5'd28: begin shift_raw = 5'd21; inverse = 17'd74899;  end
         5'd29: begin shift_raw = 5'd21; inverse = 17'd72316;  end
         5'd30: begin shift_raw = 5'd21; inverse = 17'd69906;  end
         5'd31: begin shift_raw = 5'd21; inverse = 17'd67651;  end
         default: begin shift_raw = 5'd16; inverse = 17'd65536; end
      endcase
   end

   assign shift = WIDTH_SHIFT'(shift_raw);

endmodule

// File: rtl/recip_div_ctrl.sv
// Two-requester sequencer for the reciprocal-multiply divider (lookup, shift-add multiply, +/-1 fix-up).
// Define RECIP_DIV_RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module recip_div_ctrl
   import recip_div_pkg::*;
(
   input logic             clk,
   input logic             rst,
   recip_div_ctrl_if.slave bus
);

   localparam int Q0_WIDTH = DIVIDEND_WIDTH + 1;
   localparam int QD_WIDTH = DIVIDEND_WIDTH + DIVISOR_WIDTH + 1;

   state_t state, state_next;

   logic [DIVIDEND_WIDTH-1:0] dividend_q;
   logic [DIVISOR_WIDTH-1:0]  divisor_q;
   logic                      id_q;
   logic                      zero_q;
   logic [WIDTH_INVERSE-1:0]  inverse_q;
   logic [WIDTH_SHIFT-1:0]    shift_q;
   logic [PRODUCT_WIDTH-1:0]  acc;
   logic [COUNT_WIDTH-1:0]    count;

   logic [WIDTH_INVERSE-1:0]  table_inverse;
   logic [WIDTH_SHIFT-1:0]    table_shift;

   logic                      grant;
   logic                      ready0, ready1, accept;

   logic                      out_valid_q;
   logic [DIVIDEND_WIDTH-1:0] out_quotient_q;
   logic [DIVISOR_WIDTH-1:0]  out_remainder_q;
   logic                      out_id_q;
   logic                      out_div_zero_q;

   logic [Q0_WIDTH-1:0]       q0;
   logic [QD_WIDTH-1:0]       prod0, n_ext, d_ext, diff;
   logic [DIVIDEND_WIDTH-1:0] q_fix;
   logic [DIVISOR_WIDTH-1:0]  r_fix;

   inverse_table #(.WIDTH_SHIFT(WIDTH_SHIFT)) u_table (
      .divisor (divisor_q),
      .inverse (table_inverse),
      .shift   (table_shift)
   );

`ifdef RECIP_DIV_RR_ARB_EN
   logic last_grant;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
      else if (bus.req1_valid)              grant = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)         last_grant <= 1'b1;
      else if (accept) last_grant <= grant;
   end
`else
   always_comb grant = ~bus.req0_valid & bus.req1_valid;
`endif

   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (!rst && state == IDLE) begin
         ready0 = bus.req0_valid & ~grant;
         ready1 = bus.req1_valid & grant;
      end
   end

   assign accept         = ready0 | ready1;
   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = LOOKUP;
         LOOKUP:  state_next = zero_q ? FIX : MUL;
         MUL:     if (count == COUNT_WIDTH'(DIVIDEND_WIDTH - 1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The truncated reciprocal can be off by one either way, so the fix-up nudges q0 toward the true quotient.
   always_comb begin
      q0    = Q0_WIDTH'(acc >> shift_q);
      n_ext = QD_WIDTH'(dividend_q);
      d_ext = QD_WIDTH'(divisor_q);
      prod0 = QD_WIDTH'(q0) * d_ext;
      diff  = n_ext - prod0;
      q_fix = DIVIDEND_WIDTH'(q0);
      r_fix = DIVISOR_WIDTH'(diff);
      if (prod0 > n_ext) begin
         q_fix = DIVIDEND_WIDTH'(q0 - Q0_WIDTH'(1));
         r_fix = DIVISOR_WIDTH'(diff + d_ext);
      end else if (diff >= d_ext) begin
         q_fix = DIVIDEND_WIDTH'(q0 + Q0_WIDTH'(1));
         r_fix = DIVISOR_WIDTH'(diff - d_ext);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dividend_q      <= '0;
         divisor_q       <= '0;
         id_q            <= 1'b0;
         zero_q          <= 1'b0;
         inverse_q       <= '0;
         shift_q         <= '0;
         acc             <= '0;
         count           <= '0;
         out_valid_q     <= 1'b0;
         out_quotient_q  <= '0;
         out_remainder_q <= '0;
         out_id_q        <= 1'b0;
         out_div_zero_q  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  dividend_q <= grant ? bus.req1_dividend : bus.req0_dividend;
                  divisor_q  <= grant ? bus.req1_divisor  : bus.req0_divisor;
                  zero_q     <= grant ? (bus.req1_divisor == '0) : (bus.req0_divisor == '0);
                  id_q       <= grant;
               end
            end
            LOOKUP: begin
               inverse_q <= table_inverse;
               shift_q   <= table_shift;
               acc       <= '0;
               count     <= '0;
            end
            MUL: begin
               if (dividend_q[count]) acc <= acc + (PRODUCT_WIDTH'(inverse_q) << count);
               count <= count + COUNT_WIDTH'(1);
            end
            FIX: begin
               out_valid_q     <= 1'b1;
               out_id_q        <= id_q;
               out_div_zero_q  <= zero_q;
               out_quotient_q  <= zero_q ? DIV_ZERO_QUOTIENT : q_fix;
               out_remainder_q <= zero_q ? dividend_q[DIVISOR_WIDTH-1:0] : r_fix;
            end
            DONE: begin
               if (bus.out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_quotient  = out_quotient_q;
   assign bus.out_remainder = out_remainder_q;
   assign bus.out_id        = out_id_q;
   assign bus.out_div_zero  = out_div_zero_q;

endmodule

// File: tb/tb_recip_div_ctrl.sv
// Directed bench for recip_div_ctrl: vector table, abort-on-reset, tie arbitration and output stall.
// Expected arbitration order follows RECIP_DIV_RR_ARB_EN the same way the design does.
module tb_recip_div_ctrl;
   import recip_div_pkg::*;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   recip_div_ctrl_if bus ();

   recip_div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic       src;
      logic [7:0] dividend;
      logic [4:0] divisor;
      logic [7:0] exp_q;
      logic [4:0] exp_r;
      logic       exp_zero;
      int         exp_lat;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic driveReq(input logic src, input logic [7:0] dvd, input logic [4:0] dvs);
      if (src) begin
         bus.req1_valid    = 1'b1;
         bus.req1_dividend = dvd;
         bus.req1_divisor  = dvs;
      end else begin
         bus.req0_valid    = 1'b1;
         bus.req0_dividend = dvd;
         bus.req0_divisor  = dvs;
      end
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic releaseResult(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({name, " out_valid after release"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic applyStimulus(input vec_t v, input string name);
      int   wc;
      int   lat;
      logic rdy;
      driveReq(v.src, v.dividend, v.divisor);
      #1;
      wc  = 0;
      rdy = v.src ? bus.req1_ready : bus.req0_ready;
      while (!rdy && wc < 20) begin
         @(posedge clk);
         #1;
         wc++;
         rdy = v.src ? bus.req1_ready : bus.req0_ready;
      end
      checkOutput({name, " accept"}, 32'(rdy), 32'd1);
      if (!rdy) begin
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      waitResult(lat);
      checkOutput({name, " latency"},   32'(lat),               32'(v.exp_lat));
      checkOutput({name, " quotient"},  32'(bus.out_quotient),  32'(v.exp_q));
      checkOutput({name, " remainder"}, 32'(bus.out_remainder), 32'(v.exp_r));
      checkOutput({name, " id"},        32'(bus.out_id),        32'(v.src));
      checkOutput({name, " div_zero"},  32'(bus.out_div_zero),  32'(v.exp_zero));
      releaseResult(name);
   endtask

   vec_t vecs[9];
   logic exp_ids[3];

   initial begin
      int   lat;
      int   wc;
      logic saw;
      logic src;

      vecs[0] = '{src:1'b0, dividend:8'd200, divisor:5'd7,  exp_q:8'd28,  exp_r:5'd4,  exp_zero:1'b0, exp_lat:10};
      vecs[1] = '{src:1'b1, dividend:8'd255, divisor:5'd31, exp_q:8'd8,   exp_r:5'd7,  exp_zero:1'b0, exp_lat:10};
      vecs[2] = '{src:1'b0, dividend:8'd255, divisor:5'd21, exp_q:8'd12,  exp_r:5'd3,  exp_zero:1'b0, exp_lat:10};
      vecs[3] = '{src:1'b1, dividend:8'd243, divisor:5'd27, exp_q:8'd9,   exp_r:5'd0,  exp_zero:1'b0, exp_lat:10};
      vecs[4] = '{src:1'b0, dividend:8'd100, divisor:5'd0,  exp_q:8'd255, exp_r:5'd4,  exp_zero:1'b1, exp_lat:2};
      vecs[5] = '{src:1'b1, dividend:8'd0,   divisor:5'd5,  exp_q:8'd0,   exp_r:5'd0,  exp_zero:1'b0, exp_lat:10};
      vecs[6] = '{src:1'b0, dividend:8'd255, divisor:5'd1,  exp_q:8'd255, exp_r:5'd0,  exp_zero:1'b0, exp_lat:10};
      vecs[7] = '{src:1'b1, dividend:8'd17,  divisor:5'd16, exp_q:8'd1,   exp_r:5'd1,  exp_zero:1'b0, exp_lat:10};
      vecs[8] = '{src:1'b0, dividend:8'd30,  divisor:5'd31, exp_q:8'd0,   exp_r:5'd30, exp_zero:1'b0, exp_lat:10};

`ifdef RECIP_DIV_RR_ARB_EN
      exp_ids = '{1'b0, 1'b1, 1'b0};
`else
      exp_ids = '{1'b0, 1'b0, 1'b0};
`endif

      rst               = 1'b1;
      bus.out_ready     = 1'b0;
      bus.req0_valid    = 1'b1;
      bus.req0_dividend = 8'd9;
      bus.req0_divisor  = 5'd3;
      bus.req1_valid    = 1'b1;
      bus.req1_dividend = 8'd9;
      bus.req1_divisor  = 5'd3;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ready0 during reset", 32'(bus.req0_ready), 32'd0);
      checkOutput("ready1 during reset", 32'(bus.req1_ready), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst            = 1'b0;
      #1;
      checkOutput("reset out_valid",     32'(bus.out_valid),     32'd0);
      checkOutput("reset out_quotient",  32'(bus.out_quotient),  32'd0);
      checkOutput("reset out_remainder", 32'(bus.out_remainder), 32'd0);
      checkOutput("reset out_id",        32'(bus.out_id),        32'd0);
      checkOutput("reset out_div_zero",  32'(bus.out_div_zero),  32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort: reset lands in the fourth multiply cycle of a req0 operation.
      driveReq(1'b0, 8'd200, 5'd7);
      #1;
      wc = 0;
      while (!bus.req0_ready && wc < 20) begin
         @(posedge clk);
         #1;
         wc++;
      end
      checkOutput("abort accept", 32'(bus.req0_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      saw = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) saw = 1'b1;
      end
      checkOutput("abort emits no result", 32'(saw), 32'd0);

      // Continuous tie between req0 50/3 and req1 90/9; the first result is also held to test the stall.
      driveReq(1'b0, 8'd50, 5'd3);
      driveReq(1'b1, 8'd90, 5'd9);
      for (int t = 0; t < 3; t++) begin
         #1;
         wc = 0;
         while (!(bus.req0_ready || bus.req1_ready) && wc < 30) begin
            @(posedge clk);
            #1;
            wc++;
         end
         checkOutput($sformatf("tie%0d ready0", t), 32'(bus.req0_ready), 32'(!exp_ids[t]));
         checkOutput($sformatf("tie%0d ready1", t), 32'(bus.req1_ready), 32'(exp_ids[t]));
         src = bus.req1_ready;
         @(posedge clk);
         #1;
         waitResult(lat);
         checkOutput($sformatf("tie%0d latency", t),   32'(lat),               32'd10);
         checkOutput($sformatf("tie%0d id", t),        32'(bus.out_id),        32'(exp_ids[t]));
         checkOutput($sformatf("tie%0d quotient", t),  32'(bus.out_quotient),  exp_ids[t] ? 32'd10 : 32'd16);
         checkOutput($sformatf("tie%0d remainder", t), 32'(bus.out_remainder), exp_ids[t] ? 32'd0 : 32'd2);
         if (t == 0) begin
            for (int s = 0; s < 5; s++) begin
               checkOutput($sformatf("stall%0d out_valid", s), 32'(bus.out_valid), 32'd1);
               checkOutput($sformatf("stall%0d quotient", s),
                           32'({bus.out_quotient, bus.out_remainder, bus.out_id}), 32'({8'd16, 5'd2, 1'b0}));
               checkOutput($sformatf("stall%0d readys", s), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
               @(posedge clk);
               #1;
            end
         end
         releaseResult($sformatf("tie%0d src%0d", t, src));
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
